// File: rtl/shared_net_arbiter_if.sv
// Shared-net bundle between the requesters and the arbiter.
//   req       - per-requester drive request
//   wdata     - requester i's drive value in bits [i*WIDTH +: WIDTH]
//   gnt       - registered one-hot (or zero) grant
//   bus_owner - index of the granted requester, 0 when no grant
//   bus_data  - registered value of the shared net
//   bus_valid - bus_data was captured from a granted requester last edge
interface shared_net_arbiter_if #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned WIDTH = 32
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [2:0]            bus_owner;
  logic [WIDTH-1:0]      bus_data;
  logic                  bus_valid;

  // requester side
  modport master (
    output req, wdata,
    input  gnt, bus_owner, bus_data, bus_valid
  );

  // arbiter side
  modport slave (
    input  req, wdata,
    output gnt, bus_owner, bus_data, bus_valid
  );
endinterface

// File: rtl/shared_net_arbiter.sv
// Round-robin arbiter for one shared WIDTH-bit net with a one-cycle turnaround
// between owners and a hold limit while others wait.
//   clk - clock, all state updates on posedge
//   rst - synchronous active-high reset
//   bus - shared_net_arbiter_if.slave (req/wdata in, gnt/bus_owner/bus_data/bus_valid out)
module shared_net_arbiter #(
  parameter int unsigned      NREQ       = 3,
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      MAX_HOLD   = 4,
  parameter logic [WIDTH-1:0] IDLE_VALUE = 32'hdeadbeef
) (
  input logic                  clk,
  input logic                  rst,
  shared_net_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(NREQ);
  localparam int unsigned HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t            state_q, state_nxt;
  logic [NREQ-1:0]   gnt_q, gnt_nxt;
  logic [2:0]        owner_q, owner_nxt;
  logic [2:0]        last_q, last_nxt;
  logic [WIDTH-1:0]  data_q, data_nxt;
  logic              valid_q, valid_nxt;
  logic [HOLD_W-1:0] hold_q, hold_nxt;

  logic              any_req_c;
  logic              other_req_c;
  logic              cap_c;
  logic              preempt_c;
  logic              release_c;
  logic [WIDTH-1:0]  cap_data_c;
  logic [IDX_W-1:0]  winner_c;
  logic [IDX_W-1:0]  cand_c;
  logic              found_c;

  assign any_req_c   = |bus.req;
  assign other_req_c = |(bus.req & ~gnt_q);
  // gnt is one-hot, so this is also "owner still requests"
  assign cap_c       = |(gnt_q & bus.req);
  assign preempt_c   = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD)) && other_req_c;
  assign release_c   = !cap_c || preempt_c;

  // round-robin search starting just after the last owner
  always_comb begin
    winner_c = '0;
    cand_c   = '0;
    found_c  = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand_c = IDX_W'((32'(last_q) + i) % NREQ);
      if (!found_c && bus.req[cand_c]) begin
        winner_c = cand_c;
        found_c  = 1'b1;
      end
    end
  end

  // value driven by the currently granted requester
  always_comb begin
    cap_data_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i] && bus.req[i]) cap_data_c = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= 3'(NREQ - 1);
      data_q  <= IDLE_VALUE;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_nxt;
      gnt_q   <= gnt_nxt;
      owner_q <= owner_nxt;
      last_q  <= last_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      hold_q  <= hold_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (any_req_c) state_nxt = OWN;
      OWN:     if (release_c) state_nxt = TURN;
      TURN:    state_nxt = any_req_c ? OWN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // next-output logic; capture happens in every state
  always_comb begin
    gnt_nxt   = gnt_q;
    owner_nxt = owner_q;
    last_nxt  = last_q;
    hold_nxt  = hold_q;
    data_nxt  = cap_c ? cap_data_c : data_q;
    valid_nxt = cap_c;
    case (state_q)
      IDLE, TURN: begin
        if (any_req_c) begin
          gnt_nxt   = NREQ'(1) << winner_c;
          owner_nxt = 3'(winner_c);
          hold_nxt  = HOLD_W'(1);
        end else begin
          gnt_nxt   = '0;
          owner_nxt = '0;
        end
      end
      OWN: begin
        if (release_c) begin
          gnt_nxt   = '0;
          owner_nxt = '0;
          last_nxt  = owner_q;
        end else if (MAX_HOLD != 0 && hold_q != HOLD_W'(MAX_HOLD)) begin
          hold_nxt = HOLD_W'(hold_q + 1'b1);
        end
      end
      default: begin
        gnt_nxt   = '0;
        owner_nxt = '0;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.bus_owner = owner_q;
  assign bus.bus_data  = data_q;
  assign bus.bus_valid = valid_q;

endmodule

// File: tb/tb_shared_net_arbiter.sv
// Directed bench for shared_net_arbiter: vector table plus hand sequences
// for round-robin rotation, unlimited hold and simultaneous-request priority.
module tb_shared_net_arbiter;

  localparam logic [31:0] IDLEV = 32'hdeadbeef;
  localparam logic [31:0] W0    = 32'h12345678;
  localparam logic [31:0] W1    = 32'hcafef00d;
  localparam logic [31:0] W2    = 32'ha5a5a5a5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  shared_net_arbiter_if #(.NREQ(3), .WIDTH(32)) bus ();

  shared_net_arbiter #(
    .NREQ(3), .WIDTH(32), .MAX_HOLD(4), .IDLE_VALUE(IDLEV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [2:0]  owner;
    logic [31:0] data;
    logic        valid;
  } vec_t;

  vec_t        vecs[19];
  logic [31:0] wv[3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [2:0] g, input logic [2:0] o,
                         input logic [31:0] d, input logic v);
    chk({nm, " gnt"},   32'(bus.gnt),       32'(g));
    chk({nm, " owner"}, 32'(bus.bus_owner), 32'(o));
    chk({nm, " data"},  bus.bus_data,       d);
    chk({nm, " valid"}, 32'(bus.bus_valid), 32'(v));
    chk({nm, " onehot"}, 32'($countones(bus.gnt) <= 1), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  eg, eo;
    logic [31:0] ed, prev;
    logic        ev;
    int          o;

    wv[0] = W0; wv[1] = W1; wv[2] = W2;
    //           rst   req     gnt     own   data   valid
    vecs[0]  = '{1'b1, 3'b000, 3'b000, 3'd0, IDLEV, 1'b0};
    vecs[1]  = '{1'b0, 3'b000, 3'b000, 3'd0, IDLEV, 1'b0};
    vecs[2]  = '{1'b0, 3'b000, 3'b000, 3'd0, IDLEV, 1'b0};
    vecs[3]  = '{1'b0, 3'b000, 3'b000, 3'd0, IDLEV, 1'b0};
    vecs[4]  = '{1'b0, 3'b000, 3'b000, 3'd0, IDLEV, 1'b0};
    vecs[5]  = '{1'b0, 3'b000, 3'b000, 3'd0, IDLEV, 1'b0};
    vecs[6]  = '{1'b0, 3'b001, 3'b001, 3'd0, IDLEV, 1'b0};
    vecs[7]  = '{1'b0, 3'b001, 3'b001, 3'd0, W0,    1'b1};
    vecs[8]  = '{1'b0, 3'b001, 3'b001, 3'd0, W0,    1'b1};
    vecs[9]  = '{1'b0, 3'b000, 3'b000, 3'd0, W0,    1'b0};
    vecs[10] = '{1'b0, 3'b000, 3'b000, 3'd0, W0,    1'b0};
    vecs[11] = '{1'b0, 3'b000, 3'b000, 3'd0, W0,    1'b0};
    vecs[12] = '{1'b0, 3'b010, 3'b010, 3'd1, W0,    1'b0};
    vecs[13] = '{1'b0, 3'b010, 3'b010, 3'd1, W1,    1'b1};
    vecs[14] = '{1'b1, 3'b010, 3'b000, 3'd0, IDLEV, 1'b0};
    vecs[15] = '{1'b0, 3'b110, 3'b010, 3'd1, IDLEV, 1'b0};
    vecs[16] = '{1'b0, 3'b110, 3'b010, 3'd1, W1,    1'b1};
    vecs[17] = '{1'b0, 3'b000, 3'b000, 3'd0, W1,    1'b0};
    vecs[18] = '{1'b0, 3'b000, 3'b000, 3'd0, W1,    1'b0};

    rst       = 1'b1;
    bus.req   = '0;
    bus.wdata = {W2, W1, W0};

    for (int i = 0; i < 19; i++) begin
      rst     = vecs[i].rst;
      bus.req = vecs[i].req;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].owner, vecs[i].data, vecs[i].valid);
    end

    // all three requesting: 4-cycle tenures, TURN gap, order 0,1,2,...
    rst = 1'b1; bus.req = 3'b000;
    step();
    rst = 1'b0; bus.req = 3'b111;
    prev = IDLEV;
    for (int r = 0; r < 6; r++) begin
      o = r % 3;
      for (int c = 0; c < 5; c++) begin
        step();
        eg = (c < 4) ? 3'(1 << o) : 3'b000;
        eo = (c < 4) ? 3'(o) : 3'd0;
        ed = (c == 0) ? prev : wv[o];
        ev = (c != 0);
        chk_all($sformatf("rr r%0d c%0d", r, c), eg, eo, ed, ev);
      end
      prev = wv[o];
    end

    // lone requester keeps the net indefinitely
    rst = 1'b1; bus.req = 3'b000;
    step();
    rst = 1'b0; bus.req = 3'b010;
    step();
    chk_all("solo grant", 3'b010, 3'd1, IDLEV, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step();
      chk_all($sformatf("solo c%0d", c), 3'b010, 3'd1, W1, 1'b1);
    end

    // owner 1 drops while 0 and 2 rise together: 2 follows last owner 1
    bus.req = 3'b101;
    step();
    chk_all("sim turn", 3'b000, 3'd0, W1, 1'b0);
    step();
    chk_all("sim grant", 3'b100, 3'd2, W1, 1'b0);
    step();
    chk_all("sim data", 3'b100, 3'd2, W2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
